// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared state encodings and widths for the nibble-serial subtractor
package cla_pkg;
    localparam int NIBBLES = 4;
    localparam int WIDTH   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/nibble_serial_sub_16bit_if.sv
// rtl/nibble_serial_sub_16bit_if.sv - operand/result bundle; ovf exists only with SUB_OVERFLOW_EN
interface nibble_serial_sub_16bit_if;
    import cla_pkg::*;

    logic             start;
    logic [WIDTH-1:0] in1_16bit;
    logic [WIDTH-1:0] in2_16bit;
    logic [WIDTH-1:0] diff_16bit;
    logic             borrow;
    logic             busy;
    logic             done;
`ifdef SUB_OVERFLOW_EN
    logic             ovf;

    modport master (output start, in1_16bit, in2_16bit,
                    input  diff_16bit, borrow, busy, done, ovf);
    modport slave  (input  start, in1_16bit, in2_16bit,
                    output diff_16bit, borrow, busy, done, ovf);
`else
    modport master (output start, in1_16bit, in2_16bit,
                    input  diff_16bit, borrow, busy, done);
    modport slave  (input  start, in1_16bit, in2_16bit,
                    output diff_16bit, borrow, busy, done);
`endif
endinterface

// File: rtl/cla_4bit_slice.sv
// rtl/cla_4bit_slice.sv - combinational 4-bit carry look-ahead adder slice
module cla_4bit_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s  = p ^ c;
    assign c3 = c[3];
endmodule

// File: rtl/nibble_serial_sub_16bit.sv
// rtl/nibble_serial_sub_16bit.sv - 16-bit subtractor, one nibble per cycle through a CLA slice
// Optional signed-overflow output enabled by macro SUB_OVERFLOW_EN.
module nibble_serial_sub_16bit
    import cla_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    nibble_serial_sub_16bit_if.slave bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             carry_q, carry_d;
    logic [1:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             borrow_q, borrow_d;

    logic [3:0] nib_s;
    logic       nib_cout;
`ifdef SUB_OVERFLOW_EN
    logic       nib_c3;
    logic       ovf_q, ovf_d;
`else
    logic       nib_c3_unused;
`endif

    // Subtraction as a + ~b + 1: operand b is stored inverted and carry starts at 1.
    cla_4bit_slice u_slice (
        .a    (op_a_q[{idx_q, 2'b00} +: 4]),
        .b    (op_b_q[{idx_q, 2'b00} +: 4]),
        .cin  (carry_q),
        .s    (nib_s),
        .cout (nib_cout),
`ifdef SUB_OVERFLOW_EN
        .c3   (nib_c3)
`else
        .c3   (nib_c3_unused)
`endif
    );

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        diff_d   = diff_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        borrow_d = borrow_q;
`ifdef SUB_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_a_d  = bus.in1_16bit;
                    op_b_d  = ~bus.in2_16bit;
                    carry_d = 1'b1;
                    idx_d   = 2'd0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[{idx_q, 2'b00} +: 4] = nib_s;
                carry_d = nib_cout;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    borrow_d = ~nib_cout;
`ifdef SUB_OVERFLOW_EN
                    ovf_d    = nib_c3 ^ nib_cout;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            diff_q   <= '0;
            carry_q  <= 1'b0;
            idx_q    <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            diff_q   <= diff_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            borrow_q <= borrow_d;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.diff_16bit = diff_q;
    assign bus.borrow     = borrow_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
`ifdef SUB_OVERFLOW_EN
    assign bus.ovf        = ovf_q;
`endif
endmodule

// File: doc/nibble_serial_sub_16bit.md
NIBBLE_SERIAL_SUB_16BIT -- requirements
Module: nibble_serial_sub_16bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Ports SHALL be as follows:
- clk, input, 1 bit: single clock; all state changes on the rising edge.
- rst, input, 1 bit: asynchronous active-high reset.
- start, input, 1 bit: request a subtraction; sampled only in IDLE.
- in1_16bit, input, 16 bits: minuend; captured only when start is accepted.
- in2_16bit, input, 16 bits: subtrahend; captured only when start is accepted.
- diff_16bit, output, 16 bits: in1 - in2 modulo 2^16; held until the next accepted start.
- borrow, output, 1 bit: 1 when in1 < in2 unsigned; held with diff_16bit.
- busy, output, 1 bit: high while in RUN.
- done, output, 1 bit: one-cycle pulse marking diff_16bit/borrow valid.
- ovf, output, 1 bit: signed overflow flag; present only with SUB_OVERFLOW_EN.

Function
REQ-003 The FSM SHALL have states IDLE, RUN and DONE, encoded in 2 bits.
REQ-004 In IDLE with start=1 at edge E0, the block SHALL:
- capture in1 and ~in2 into operand registers;
- set the carry register to 1;
- set the nibble index to 0;
- enter RUN with busy=1.
REQ-005 At each RUN edge E1..E4, the block SHALL add one nibble, LSB first, through the 4-bit CLA slice: nibble[i] = in1[i] + ~in2[i] + carry.
- The 4-bit sum is written to diff_16bit[4i+3:4i].
- The slice carry-out is written to the carry register.
REQ-006 Nibble index bits[1:0] SHALL increment each RUN cycle.
- At index 3 (edge E4) the FSM SHALL enter DONE with busy=0 and done=1.
- borrow SHALL be set to the inverse of the final carry at the same edge.
REQ-007 Start-to-done latency SHALL be fixed at 4 cycles: done is high during the cycle after E4 and no longer.
REQ-008 DONE SHALL return to IDLE unconditionally on the next edge (E5), with done returning to 0.
REQ-009 start asserted in RUN or DONE SHALL be ignored, not queued; changes on in1/in2 outside acceptance SHALL have no effect.
REQ-010 A start held high continuously SHALL be re-accepted in the first IDLE cycle, so an operation begins every 6 cycles.
REQ-011 diff_16bit SHALL be updated nibble by nibble during RUN; only its value while done=1 or later in IDLE is defined.

Reset
REQ-012 When rst=1, without waiting for a clock edge, the block SHALL set:
- state to IDLE;
- busy=0 and done=0;
- diff_16bit=16'h0000 and borrow=0 (and ovf=0 when present);
- carry, operand and index registers to 0.
REQ-013 Reset asserted during RUN SHALL abort the operation with no done pulse; the next start after reset deassertion SHALL behave as from power-up.

Configuration
REQ-014 With macro SUB_OVERFLOW_EN defined, port ovf SHALL exist.
- It is set at E4 to carry-into-bit15 XOR carry-out-of-bit15.
- The carry into bit 15 SHALL be exported from the slice.
REQ-015 Without SUB_OVERFLOW_EN, the ovf port and all related logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-016 A shared package cla_pkg SHALL hold:
- the state encodings IDLE, RUN and DONE;
- NIBBLES=4 and WIDTH=16.
REQ-017 The nibble adder SHALL be a sub-module cla_4bit_slice with:
- inputs a[3:0], b[3:0], cin;
- outputs s[3:0], cout, c3 (carry into bit 3);
- purely combinational generate/propagate carry look-ahead logic;
- exactly one instance.

Verification
REQ-018 in1=16'h1234, in2=16'h0034, start pulse -> done 4 cycles later, diff=16'h1200, borrow=0.
REQ-019 in1=16'h0000, in2=16'h0001 -> diff=16'hFFFF, borrow=1; in1=in2=16'hFFFF -> diff=16'h0000, borrow=0.
REQ-020 With SUB_OVERFLOW_EN: in1=16'h8000, in2=16'h0001 -> diff=16'h7FFF, borrow=0, ovf=1; in1=16'h0005, in2=16'h0003 -> ovf=0.
REQ-021 start pulsed again with new operands on E2 -> ignored; result is that of the first operands, with exactly one done pulse.
REQ-022 rst pulsed between E2 and E3 -> all outputs 0 immediately and no done pulse; a fresh start of 16'hA000-16'h0001 then gives 16'h9FFF.
REQ-023 start held high for 20 cycles -> done pulses exactly every 6 cycles, and busy is never high in the same cycle as done.
